// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings and constants for the execute-stage datapath
package exec_pkg;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_AND    = 4'h2,
    ALU_OR     = 4'h3,
    ALU_XOR    = 4'h4,
    ALU_SLL    = 4'h5,
    ALU_SRL    = 4'h6,
    ALU_SRA    = 4'h7,
    ALU_SLT    = 4'h8,
    ALU_SLTU   = 4'h9,
    ALU_PASS_B = 4'hA
  } alu_op_t;
  typedef enum logic [1:0] {
    B_IMM_I   = 2'b00,
    B_IMM_S   = 2'b01,
    B_RS2     = 2'b10,
    B_RS2_ALT = 2'b11
  } bsel_t;
  localparam logic [31:0] PC_STEP_SEQ = 32'd4;
endpackage

// File: rtl/exec_datapath_if.sv
// exec_datapath_if: operand, control and result bundle of the execute stage
interface exec_datapath_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [1:0]      b_sel;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] branch_off;
  logic            pc_sel;
  logic [XLEN-1:0] alu_out;
  logic            zero;
  logic [XLEN-1:0] pc_step;
  logic [XLEN-1:0] alu_out_q;
  logic            zero_q;
  modport master (
    output rs1_data, rs2_data, imm_i, imm_s, b_sel, alu_op, branch_off, pc_sel,
    input  alu_out, zero, pc_step, alu_out_q, zero_q
  );
  modport slave (
    input  rs1_data, rs2_data, imm_i, imm_s, b_sel, alu_op, branch_off, pc_sel,
    output alu_out, zero, pc_step, alu_out_q, zero_q
  );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: combinational RV32I ALU with zero flag
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] y_o,
  output logic            zero_o
);
  logic [4:0] shamt;
  assign shamt = b_i[4:0];
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:    y_o = a_i + b_i;
      ALU_SUB:    y_o = a_i - b_i;
      ALU_AND:    y_o = a_i & b_i;
      ALU_OR:     y_o = a_i | b_i;
      ALU_XOR:    y_o = a_i ^ b_i;
      ALU_SLL:    y_o = a_i << shamt;
      ALU_SRL:    y_o = a_i >> shamt;
      ALU_SRA:    y_o = $signed(a_i) >>> shamt;
      ALU_SLT:    y_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU:   y_o = XLEN'(a_i < b_i);
      ALU_PASS_B: y_o = b_i;
      default:    y_o = '0;
    endcase
  end
  assign zero_o = ~|y_o;
endmodule

// File: rtl/exec_datapath.sv
// exec_datapath: B-operand mux, ALU, PC-step mux and registered result copy
module exec_datapath
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  exec_datapath_if.slave bus
);
  bsel_t           b_sel;
  logic [XLEN-1:0] b_op;
  logic [XLEN-1:0] alu_out_d, alu_out_q;
  logic            zero_d, zero_q;
  assign b_sel = bsel_t'(bus.b_sel);
  always_comb
    b_op = (b_sel == B_IMM_I) ? bus.imm_i :
           (b_sel == B_IMM_S) ? bus.imm_s : bus.rs2_data;
  exec_alu #(.XLEN(XLEN)) u_alu (
    .a_i    (bus.rs1_data),
    .b_i    (b_op),
    .op_i   (alu_op_t'(bus.alu_op)),
    .y_o    (alu_out_d),
    .zero_o (zero_d)
  );
  assign bus.alu_out = alu_out_d;
  assign bus.zero    = zero_d;
  assign bus.pc_step = bus.pc_sel ? bus.branch_off : XLEN'(PC_STEP_SEQ);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end
  assign bus.alu_out_q = alu_out_q;
  assign bus.zero_q    = zero_q;
endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: directed vectors with literal checks plus a per-cycle reference model
module tb_exec_datapath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q = '0;
  logic        exp_zq = 1'b0;
  exec_datapath_if #(.XLEN(32)) bus ();
  exec_datapath #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_b(input logic [1:0] bs, input logic [31:0] rs2, ii, is);
    if (bs == 2'd0) return ii;
    if (bs == 2'd1) return is;
    return rs2;
  endfunction
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    int s;
    s = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << s;
      4'd6:  return a >> s;
      4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd9:  return {31'd0, a < b};
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] ref_now();
    return ref_alu(bus.alu_op, bus.rs1_data, ref_b(bus.b_sel, bus.rs2_data, bus.imm_i, bus.imm_s));
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      exp_zq <= 1'b0;
    end else begin
      exp_q  <= ref_now();
      exp_zq <= (ref_now() == 32'd0);
    end
  end
  always @(negedge clk) begin
    chk("model_alu_out", bus.alu_out, ref_now());
    chk("model_zero", {31'd0, bus.zero}, {31'd0, ref_now() == 32'd0});
    chk("model_pc_step", bus.pc_step, bus.pc_sel ? bus.branch_off : 32'd4);
    chk("model_alu_out_q", bus.alu_out_q, exp_q);
    chk("model_zero_q", {31'd0, bus.zero_q}, {31'd0, exp_zq});
  end
  task automatic drive(input logic [3:0] op, input logic [1:0] bs,
                       input logic [31:0] a, rs2, ii, is);
    @(posedge clk);
    #1;
    bus.alu_op = op; bus.b_sel = bs; bus.rs1_data = a;
    bus.rs2_data = rs2; bus.imm_i = ii; bus.imm_s = is;
    #1;
  endtask
  task automatic lit(input string n, input logic [31:0] y, input logic z);
    chk({n, "_out"}, bus.alu_out, y);
    chk({n, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
  endtask
  initial begin
    bus.rs1_data = '0; bus.rs2_data = '0; bus.imm_i = '0; bus.imm_s = '0;
    bus.b_sel = '0; bus.alu_op = '0; bus.branch_off = '0; bus.pc_sel = 1'b0;
    #1;
    chk("reset_q", bus.alu_out_q, 32'd0);
    chk("reset_zq", {31'd0, bus.zero_q}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(4'd0, 2'b00, 32'd5, 32'd0, 32'd7, 32'd0);
    lit("add", 32'd12, 1'b0);
    @(posedge clk); #1;
    chk("add_q", bus.alu_out_q, 32'd12);
    drive(4'd1, 2'b10, 32'h1234, 32'h1234, 32'd0, 32'd0);
    lit("sub_eq", 32'd0, 1'b1);
    chk("pc_step_seq", bus.pc_step, 32'd4);
    drive(4'd1, 2'b10, 32'h1234, 32'h1235, 32'd0, 32'd0);
    lit("sub_ne", 32'hFFFF_FFFF, 1'b0);
    drive(4'd1, 2'b11, 32'h1234, 32'h1235, 32'd9, 32'd9);
    lit("sub_bsel11", 32'hFFFF_FFFF, 1'b0);
    drive(4'd7, 2'b00, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    lit("sra", 32'hF800_0000, 1'b0);
    drive(4'd6, 2'b00, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
    lit("srl", 32'h0800_0000, 1'b0);
    drive(4'd5, 2'b00, 32'h8000_0000, 32'd0, 32'h24, 32'd0);
    lit("sll_b24", 32'd0, 1'b1);
    drive(4'd5, 2'b10, 32'h0000_0003, 32'hFFFF_FFE1, 32'd0, 32'd0);
    lit("sll_hi_ignored", 32'd6, 1'b0);
    drive(4'd8, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    lit("slt", 32'd1, 1'b0);
    drive(4'd9, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    lit("sltu", 32'd0, 1'b1);
    drive(4'd0, 2'b01, 32'h100, 32'd0, 32'd0, 32'hFFFF_FFFC);
    lit("add_imm_s", 32'hFC, 1'b0);
    drive(4'd2, 2'b10, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0);
    lit("and", 32'h00F0_1200, 1'b0);
    drive(4'd3, 2'b10, 32'hF0F0_0000, 32'h0000_1234, 32'd0, 32'd0);
    lit("or", 32'hF0F0_1234, 1'b0);
    drive(4'd4, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 32'd0, 32'd0);
    lit("xor", 32'h00FF_FF00, 1'b0);
    drive(4'd10, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'd0);
    lit("pass_b", 32'h1234_5000, 1'b0);
    bus.pc_sel = 1'b1; bus.branch_off = 32'hFFFF_FFF8; #1;
    chk("pc_step_branch", bus.pc_step, 32'hFFFF_FFF8);
    bus.pc_sel = 1'b0; #1;
    chk("pc_step_back", bus.pc_step, 32'd4);
    for (int op = 11; op < 16; op++) begin
      drive(4'(op), 2'b10, 32'h55, 32'h33, 32'd0, 32'd0);
      lit("undef_op", 32'd0, 1'b1);
    end
    drive(4'd0, 2'b00, 32'd5, 32'd0, 32'd7, 32'd0);
    @(posedge clk); #1;
    chk("pre_rst_q", bus.alu_out_q, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", bus.alu_out_q, 32'd0);
    chk("async_rst_zq", {31'd0, bus.zero_q}, 32'd0);
    chk("rst_comb_out", bus.alu_out, 32'd12);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_q", bus.alu_out_q, 32'd12);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_datapath.md
# exec_datapath

Execute-stage datapath of the single-cycle RV32I core. It selects the ALU B operand from three sources, computes the ALU result and zero flag, and selects the PC step. The PC step is either 4 or the branch offset. The block sits between the register bank / immediate generators and the data memory / PC adder. It also holds a registered copy of the last result for debug and forwarding.

## Interface
Parameters:
- `XLEN`, default 32, datapath width.

Ports:
- `clk` in 1: single clock; all flops update on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rs1_data` in XLEN: register bank port A (DOA); this is ALU operand A.
- `rs2_data` in XLEN: register bank port B (DOB).
- `imm_i` in XLEN: sign-extended I-type immediate.
- `imm_s` in XLEN: sign-extended S-type immediate (from the imm[11:5] and imm[4:0] fields).
- `b_sel` in 2: B operand select.
- `alu_op` in 4: ALU operation.
- `branch_off` in XLEN: sign-extended B-type offset.
- `pc_sel` in 1: 0 selects PC step 4; 1 selects the branch offset.
- `alu_out` out XLEN: combinational ALU result; drives the memory address and the writeback mux.
- `zero` out 1: combinational; 1 when `alu_out` is 0.
- `pc_step` out XLEN: combinational; addend for the PC adder.
- `alu_out_q` out XLEN: registered `alu_out`.
- `zero_q` out 1: registered `zero`.

## Operation
B operand mux (`b_sel`):
- 00 selects `imm_i`.
- 01 selects `imm_s`.
- 10 selects `rs2_data`.
- 11 selects `rs2_data`.

ALU, with A = `rs1_data` and B = the mux output:
- 0000 ADD: A+B, modulo 2^XLEN, no carry out.
- 0001 SUB: A−B, modulo 2^XLEN.
- 0010 AND.
- 0011 OR.
- 0100 XOR.
- 0101 SLL: A << B[4:0].
- 0110 SRL: A >> B[4:0], logical.
- 0111 SRA: A >>> B[4:0], sign-filled.
- 1000 SLT: signed A<B gives 1, otherwise 0, zero-extended.
- 1001 SLTU: unsigned compare, same result format.
- 1010 PASS_B: result is B (used by LUI).
- 1011–1111: result is 0, so `zero` = 1.

Other rules:
- Shift amount uses only B[4:0]; upper bits of B are ignored.
- `zero` = (`alu_out` == 0) for every op. The control unit uses `zero` after SUB for BEQ/BNE.
- PC step mux: `pc_step` = `pc_sel` ? `branch_off` : 32'd4.
- No latches: every combinational path assigns all outputs under all select values.

## Timing
- `alu_out`, `zero` and `pc_step` are purely combinational, with zero latency. They settle within the same cycle as their inputs.
- `alu_out_q` and `zero_q` capture `alu_out` and `zero` on every rising `clk`. There is no enable.
- While `rst_n` = 0:
  - `alu_out_q` = 0 and `zero_q` = 0 immediately, without waiting for a clock edge.
  - The combinational outputs still follow their inputs.
- On `rst_n` deassertion, the first rising edge loads the current result.
- Reset asserted mid-operation clears only the registered outputs.
- No handshake: the block accepts new operands every cycle.

## Structure
- Package `exec_pkg` holds:
  - `alu_op_t`, a 4-bit enum with the encodings above.
  - `bsel_t`, a 2-bit enum.
  - the constant `PC_STEP_SEQ` = 32'd4.
- Sub-module `exec_alu` is purely combinational and contains the ALU and the zero flag.
- The top level contains:
  - the B mux,
  - the PC step mux,
  - the result register.

## Test plan
- ADD: `rs1_data`=5, `imm_i`=7, `b_sel`=00, `alu_op`=0000. Required: `alu_out`=12, `zero`=0; the next edge gives `alu_out_q`=12.
- SUB for BNE: `rs1_data`=`rs2_data`=0x1234, `b_sel`=10, `alu_op`=0001. Required: `alu_out`=0, `zero`=1. With `pc_sel`=0, `pc_step`=4. Then set `rs2_data`=0x1235: `alu_out`=0xFFFFFFFF, `zero`=0.
- Shifts: A=0x80000000, B=4.
  - SRA gives 0xF8000000.
  - SRL gives 0x08000000.
  - SLL with B=0x24 gives 0 (shift amount is 4 from B[4:0]).
- Compares: A=0xFFFFFFFF, B=1. SLT gives 1; SLTU gives 0. S-type source: `b_sel`=01, `imm_s`=0xFFFFFFFC, ADD with A=0x100 gives 0xFC.
- Branch step: `pc_sel`=1 with `branch_off`=0xFFFFFFF8 gives `pc_step`=0xFFFFFFF8; `pc_sel`=0 gives 4. PASS_B with `imm_i`=0x12345000 gives 0x12345000.
- Reset: with `alu_out_q` nonzero, assert `rst_n`=0 between clock edges. Required: `alu_out_q`=0 and `zero_q`=0 at once, while `alu_out` is unaffected; after release, the next edge reloads `alu_out_q`.
